// File: rtl/lazy_writeback_packer.sv
// Packs SPLIT narrow beats of lazy-reduction results into full E-lane rows.
// Each completed row is written to a pair of buffer RAMs one cycle after the beat that completes it.
module lazy_writeback_packer #(
   parameter int E     = 8,
   parameter int FSIZE = 64,
   parameter int WIDTH = 10,
   parameter int SPLIT = 2
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic                        in_last,
   input  logic [(E/SPLIT)*FSIZE-1:0]  in_data1,
   input  logic [(E/SPLIT)*FSIZE-1:0]  in_data2,
   output logic                        wren,
   output logic [WIDTH-1:0]            waddr,
   output logic [E*FSIZE-1:0]          wdata1,
   output logic [E*FSIZE-1:0]          wdata2,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);
   localparam int LANES = E / SPLIT;
   localparam int LW    = LANES * FSIZE;
   localparam int SW    = (SPLIT > 1) ? $clog2(SPLIT) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(SPLIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_PACK, S_DONE} state_t;

   state_t             r_state;
   logic [SW-1:0]      r_slot;
   logic [WIDTH-1:0]   r_row;
   logic               r_wrap;
   logic [E*FSIZE-1:0] r_acc1, r_acc2;
   logic [E*FSIZE-1:0] w_acc1, w_acc2;
   logic               w_full, w_wr;

   // Accumulator with the current beat merged into its slot's lanes.
   always_comb begin
      w_acc1 = r_acc1;
      w_acc2 = r_acc2;
      w_acc1[int'(r_slot)*LW +: LW] = in_data1;
      w_acc2[int'(r_slot)*LW +: LW] = in_data2;
   end

   assign w_full = (r_slot == LAST_SLOT);
   assign w_wr   = w_full || in_last;
   assign busy   = (r_state != S_IDLE) || wren;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_slot  <= '0;
         r_row   <= '0;
         r_wrap  <= 1'b0;
         r_acc1  <= '0;
         r_acc2  <= '0;
         wren    <= 1'b0;
         waddr   <= '0;
         wdata1  <= '0;
         wdata2  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         wren <= 1'b0;
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_PACK;
                  r_slot  <= '0;
                  r_row   <= '0;
                  r_wrap  <= 1'b0;
                  r_acc1  <= '0;
                  r_acc2  <= '0;
                  err     <= in_valid;
               end else if (in_valid) begin
                  err <= 1'b1;
               end
            end
            S_PACK: begin
               if (in_valid) begin
                  if (w_wr) begin
                     wren   <= 1'b1;
                     waddr  <= r_row;
                     wdata1 <= w_acc1;
                     wdata2 <= w_acc2;
                     r_acc1 <= '0;
                     r_acc2 <= '0;
                     r_row  <= r_row + 1'b1;
                     r_slot <= '0;
                     // A row count of exactly 2^WIDTH is legal; only a write past it is an error.
                     if (r_row == '1) r_wrap <= 1'b1;
                     if (r_wrap || !w_full) err <= 1'b1;
                  end else begin
                     r_acc1 <= w_acc1;
                     r_acc2 <= w_acc2;
                     r_slot <= r_slot + 1'b1;
                  end
                  if (in_last) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               if (in_valid) err <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lazy_writeback_packer.sv
// Scoreboard bench for lazy_writeback_packer: the beat driver predicts every row
// write into a queue, and a negedge monitor pops and compares each DUT write.
module tb_lazy_writeback_packer;
   localparam int E = 8, FSIZE = 64, WIDTH = 10, SPLIT = 2;
   localparam int LANES = E / SPLIT;
   localparam int LW = LANES * FSIZE;
   localparam int DW = E * FSIZE;

   typedef logic [DW-1:0] dw_t;
   typedef logic [LW-1:0] lw_t;
   typedef struct {
      logic [WIDTH-1:0] a;
      dw_t              d1;
      dw_t              d2;
   } wr_t;

   logic             clk = 1'b0, rst = 1'b1;
   logic             start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   lw_t              in_data1 = '0, in_data2 = '0;
   logic             wren, busy, done, err;
   logic [WIDTH-1:0] waddr;
   dw_t              wdata1, wdata2;

   lazy_writeback_packer #(.E(E), .FSIZE(FSIZE), .WIDTH(WIDTH), .SPLIT(SPLIT)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
      .in_data1(in_data1), .in_data2(in_data2), .wren(wren), .waddr(waddr),
      .wdata1(wdata1), .wdata2(wdata2), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   int  n_cmp = 0, n_bad = 0;
   int  cyc = 0, n_wr = 0, first_cyc = -1, last_cyc = -1;
   wr_t sbq[$];

   // reference model state
   dw_t              m_acc1, m_acc2;
   int               m_slot;
   logic [WIDTH-1:0] m_row;

   task automatic chk(input string tag, input dw_t obs, input dw_t exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wren) begin
         if (sbq.size() == 0) begin
            chk("unexpected_wren", dw_t'(wren), '0);
         end else begin
            wr_t w;
            w = sbq.pop_front();
            chk("waddr", dw_t'(waddr), dw_t'(w.a));
            chk("wdata1", wdata1, w.d1);
            chk("wdata2", wdata2, w.d2);
         end
         n_wr++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
   end

   function automatic lw_t rnd();
      lw_t v;
      for (int i = 0; i < LANES; i++) v[i*FSIZE +: FSIZE] = {$urandom, $urandom};
      return v;
   endfunction

   task automatic start_pass();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_acc1 = '0; m_acc2 = '0; m_slot = 0; m_row = '0;
      n_wr = 0; first_cyc = -1; last_cyc = -1;
   endtask

   task automatic beat(input lw_t d1, input lw_t d2, input logic last);
      in_valid = 1'b1; in_last = last; in_data1 = d1; in_data2 = d2;
      m_acc1[m_slot*LW +: LW] = d1;
      m_acc2[m_slot*LW +: LW] = d2;
      if (m_slot == SPLIT-1 || last) begin
         sbq.push_back('{a: m_row, d1: m_acc1, d2: m_acc2});
         m_acc1 = '0; m_acc2 = '0; m_slot = 0; m_row = m_row + 1'b1;
      end else begin
         m_slot++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      lw_t a, b;
      #1;
      chk("rst_wren", dw_t'(wren), '0);
      chk("rst_waddr", dw_t'(waddr), '0);
      chk("rst_wdata1", wdata1, '0);
      chk("rst_wdata2", wdata2, '0);
      chk("rst_busy", dw_t'(busy), '0);
      chk("rst_done", dw_t'(done), '0);
      chk("rst_err", dw_t'(err), '0);
      idle(2);
      rst = 1'b0;
      idle(1);

      // two beats with lanes 1..4 and 5..8
      start_pass();
      for (int i = 0; i < LANES; i++) begin
         a[i*FSIZE +: FSIZE] = 64'(i + 1);
         b[i*FSIZE +: FSIZE] = 64'(i + 101);
      end
      beat(a, b, 1'b0);
      for (int i = 0; i < LANES; i++) begin
         a[i*FSIZE +: FSIZE] = 64'(i + 5);
         b[i*FSIZE +: FSIZE] = 64'(i + 105);
      end
      beat(a, b, 1'b1);
      chk("t1_wren", dw_t'(wren), 1);
      chk("t1_done", dw_t'(done), 1);
      chk("t1_busy_wr", dw_t'(busy), 1);
      chk("t1_wdata1_const", wdata1, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
      idle(1);
      chk("t1_busy_after", dw_t'(busy), '0);
      chk("t1_done_after", dw_t'(done), '0);
      chk("t1_nwr", dw_t'(n_wr), 1);
      chk("t1_err", dw_t'(err), '0);

      // full row space, back-to-back
      start_pass();
      for (int i = 0; i < 2048; i++) beat(rnd(), rnd(), i == 2047);
      idle(2);
      chk("t2_nwr", dw_t'(n_wr), 1024);
      chk("t2_rate", dw_t'(last_cyc - first_cyc), 2046);
      chk("t2_err", dw_t'(err), '0);
      chk("t2_sbq_empty", dw_t'(sbq.size()), '0);

      // partial final row
      start_pass();
      for (int i = 0; i < 3; i++) beat(rnd(), rnd(), i == 2);
      idle(2);
      chk("t3_nwr", dw_t'(n_wr), 2);
      chk("t3_err", dw_t'(err), 1);
      chk("t3_sbq_empty", dw_t'(sbq.size()), '0);

      // row wrap past 2^WIDTH
      start_pass();
      chk("t4_err_cleared", dw_t'(err), '0);
      for (int i = 0; i < 2050; i++) beat(rnd(), rnd(), i == 2049);
      idle(2);
      chk("t4_nwr", dw_t'(n_wr), 1025);
      chk("t4_err", dw_t'(err), 1);
      chk("t4_sbq_empty", dw_t'(sbq.size()), '0);

      // reset mid-pass
      start_pass();
      beat(rnd(), rnd(), 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t5_wren", dw_t'(wren), '0);
      chk("t5_waddr", dw_t'(waddr), '0);
      chk("t5_wdata1", wdata1, '0);
      chk("t5_busy", dw_t'(busy), '0);
      chk("t5_err", dw_t'(err), '0);
      idle(1);
      rst = 1'b0;
      in_valid = 1'b1; in_data1 = rnd(); in_data2 = rnd();
      idle(2);
      in_valid = 1'b0;
      idle(2);
      chk("t5_nwr", dw_t'(n_wr), '0);
      chk("t5_busy_after", dw_t'(busy), '0);

      // stray beat in IDLE, then start clears err; start+in_valid sets it again
      rst = 1'b1; #1 rst = 1'b0;
      idle(1);
      in_valid = 1'b1;
      idle(1);
      in_valid = 1'b0;
      idle(1);
      chk("t6_err_set", dw_t'(err), 1);
      chk("t6_nwr", dw_t'(n_wr), '0);
      start_pass();
      chk("t6_err_clr", dw_t'(err), '0);
      beat(rnd(), rnd(), 1'b0);
      beat(rnd(), rnd(), 1'b1);
      idle(2);
      chk("t6_err_clean", dw_t'(err), '0);
      start = 1'b1; in_valid = 1'b1;
      idle(1);
      start = 1'b0; in_valid = 1'b0;
      m_acc1 = '0; m_acc2 = '0; m_slot = 0; m_row = '0; n_wr = 0;
      chk("t6_err_both", dw_t'(err), 1);
      chk("t6_busy_both", dw_t'(busy), 1);
      beat(rnd(), rnd(), 1'b0);
      beat(rnd(), rnd(), 1'b1);
      idle(2);
      chk("t6_nwr_both", dw_t'(n_wr), 1);
      chk("t6_sbq_empty", dw_t'(sbq.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lazy_writeback_packer.md
LAZY_WRITEBACK_PACKER -- requirements
Module: lazy_writeback_packer

Interface
REQ-001 SHALL have parameter E, default 8: total lanes per buffer RAM row; power of two, >= 2.
REQ-002 SHALL have parameter FSIZE, default 64: bits per lane element.
REQ-003 SHALL have parameter WIDTH, default 10: row address bits; row space is 2^WIDTH.
REQ-004 SHALL have parameter SPLIT, default 2: input beats per row; power of two, divides E. LANES = E/SPLIT.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that arms a new vector pass.
REQ-008 SHALL have port in_valid, input, 1: the current beat of lazy-reduction results is valid.
REQ-009 SHALL have port in_last, input, 1: the current beat is the final beat of the pass; qualified by in_valid.
REQ-010 SHALL have port in_data1, input, LANES*FSIZE: out1 results; lane i at bits [i*FSIZE +: FSIZE].
REQ-011 SHALL have port in_data2, input, LANES*FSIZE: out2 results; same lane layout as in_data1.
REQ-012 SHALL have port wren, output, 1: buffer RAM write enable.
REQ-013 SHALL have port waddr, output, WIDTH: buffer RAM row address.
REQ-014 SHALL have port wdata1, output, E*FSIZE: packed out1 row for the op1 buffer.
REQ-015 SHALL have port wdata2, output, E*FSIZE: packed out2 row for the op2 buffer.
REQ-016 SHALL have port busy, output, 1: high in PACK or DONE state, or while wren is high.
REQ-017 SHALL have port done, output, 1: one-cycle pulse marking the end of a pass.
REQ-018 SHALL have port err, output, 1: sticky protocol error flag.

Function
REQ-019 States SHALL be IDLE, PACK and DONE.
REQ-020 IDLE -> PACK SHALL occur on start; the same cycle SHALL clear slot counter, row counter and both lane accumulators to zero.
REQ-021 In PACK, an accepted beat (in_valid=1) SHALL be written to accumulator lanes slot*LANES+i, for i in 0..LANES-1, from in_data1/in_data2 lane i, after which slot SHALL increment modulo SPLIT.
REQ-022 When the accepted beat has slot == SPLIT-1, the next cycle SHALL have wren=1, waddr=row and wdata1/wdata2 = the complete accumulator including that beat; row SHALL then increment. Write latency is 1 cycle after the completing beat.
REQ-023 wren SHALL be high for exactly one cycle per completed row; wdata1, wdata2 and waddr SHALL be registered outputs.
REQ-024 After a write, the accumulator SHALL be cleared to zero.
REQ-025 Beats SHALL be accepted back-to-back every cycle with no stall; there is no backpressure.
REQ-026 On in_last with slot != SPLIT-1, the partial row SHALL be written next cycle with all unfilled lanes zero, and err SHALL be set.
REQ-027 An accepted beat with in_last=1 SHALL move the block PACK -> DONE; the final row write and done=1 SHALL occur in the same cycle, then DONE -> IDLE.
REQ-028 When row wraps from 2^WIDTH-1 to 0, waddr SHALL wrap modulo 2^WIDTH and err SHALL be set.
REQ-029 in_valid in IDLE or DONE SHALL be dropped and SHALL set err.
REQ-030 start in PACK or DONE SHALL be ignored.
REQ-031 start and in_valid together in IDLE: start SHALL take effect and the beat SHALL be dropped and SHALL set err.
REQ-032 err SHALL clear only on rst or on an accepted start.

Reset
REQ-033 On rst assertion, immediately and independent of clk: state=IDLE, wren=0, waddr=0, wdata1=0, wdata2=0, busy=0, done=0, err=0, and all counters and accumulators zero.
REQ-034 rst mid-pass SHALL abandon the pass with no further writes; a new pass SHALL need a new start.

Verification
REQ-035 start, then 2 beats with lane values 1..4 and 5..8, in_last on beat 2 -> next cycle wren=1, waddr=0, wdata1 lanes 0..7 = 1..8, done=1; then busy=0.
REQ-036 start, then 2048 back-to-back beats, last flagged -> 1024 writes, waddr 0..1023 consecutive, one write every 2 cycles, err=0.
REQ-037 start, then 3 beats, last flagged on beat 3 -> row 1 written with lanes 4..7 = 0, err=1.
REQ-038 start, then 2050 beats -> final write at waddr=0, err=1.
REQ-039 rst pulsed after beat 1 of a row -> all outputs 0 immediately; no wren follows subsequent beats.
REQ-040 in_valid pulsed while IDLE -> no wren, err=1; a following start clears err to 0.
